// File: rtl/matmul_stream_host_if.sv
// Stream, multiplier and status signals of the 3x3 matmul host.
// master = host side, slave = upstream/downstream/multiplier side.
interface matmul_stream_host_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mm_start;
    logic [71:0] mm_A_flat;
    logic [71:0] mm_B_flat;
    logic [71:0] mm_C_flat;
    logic        mm_done;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        err;

    modport master (
        input  in_valid, in_data, mm_C_flat, mm_done, out_ready,
        output in_ready, mm_start, mm_A_flat, mm_B_flat,
        output out_valid, out_data, out_last, busy, err
    );

    modport slave (
        output in_valid, in_data, mm_C_flat, mm_done, out_ready,
        input  in_ready, mm_start, mm_A_flat, mm_B_flat,
        input  out_valid, out_data, out_last, busy, err
    );
endinterface

// File: rtl/matmul_stream_host.sv
// Host for a 3x3 8-bit matrix multiplier: loads A then B from a stream,
// starts the multiplier, waits for done (with timeout), streams C out.
module matmul_stream_host #(
    parameter int DONE_TIMEOUT = 1023
) (
    input logic                  clk,
    input logic                  reset,
    matmul_stream_host_if.master bus
);

    typedef enum logic [1:0] {LOAD, START, WAIT, SEND} state_t;

    localparam int TW = (DONE_TIMEOUT < 2) ? 1 : $clog2(DONE_TIMEOUT + 1);

    state_t        state;
    state_t        state_nx;
    logic [4:0]    idx;
    logic [3:0]    oidx;
    logic [TW-1:0] tcnt;
    logic [71:0]   a_q;
    logic [71:0]   b_q;
    logic [71:0]   c_q;
    logic          armed;
    logic          err_q;
    logic          timeout;
    logic          in_hs;
    logic          out_hs;

    assign in_hs  = bus.in_valid && bus.in_ready;
    assign out_hs = bus.out_valid && bus.out_ready;

    // State register; reset parks the FSM in LOAD.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= state_nx;
    end

    // Next-state logic and per-state handshake outputs.
    always_comb begin
        state_nx      = state;
        bus.in_ready  = 1'b0;
        bus.mm_start  = 1'b0;
        bus.out_valid = 1'b0;
        timeout       = 1'b0;
        unique case (state)
            LOAD: begin
                bus.in_ready = armed;
                if (bus.in_valid && armed && idx == 5'd17)
                    state_nx = START;
            end
            START: begin
                bus.mm_start = 1'b1;
                state_nx     = WAIT;
            end
            WAIT: begin
                if (bus.mm_done) begin
                    state_nx = SEND;
                end else if (DONE_TIMEOUT != 0 &&
                             int'(tcnt) + 1 == DONE_TIMEOUT) begin
                    timeout  = 1'b1;
                    state_nx = LOAD;
                end
            end
            SEND: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready && oidx == 4'd8)
                    state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    // Operand load, timeout count, result capture, output index, error flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx   <= '0;
            oidx  <= '0;
            tcnt  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            armed <= 1'b0;
            err_q <= 1'b0;
        end else begin
            armed <= 1'b1;
            for (int k = 0; k < 9; k++) begin
                if (in_hs && idx == 5'(k))
                    a_q[71-8*k -: 8] <= bus.in_data;
                if (in_hs && idx == 5'(k + 9))
                    b_q[71-8*k -: 8] <= bus.in_data;
            end
            if (in_hs)
                idx <= (idx == 5'd17) ? 5'd0 : idx + 5'd1;
            if (state == START)
                tcnt <= '0;
            else if (state == WAIT && !bus.mm_done)
                tcnt <= tcnt + 1'b1;
            if (state == WAIT && bus.mm_done)
                c_q <= bus.mm_C_flat;
            if (timeout) begin
                err_q <= 1'b1;
                idx   <= '0;
            end
            if (out_hs)
                oidx <= (oidx == 4'd8) ? 4'd0 : oidx + 4'd1;
        end
    end

    // Select the captured result element addressed by oidx.
    always_comb begin
        bus.out_data = 8'd0;
        for (int k = 0; k < 9; k++)
            if (oidx == 4'(k))
                bus.out_data = c_q[71-8*k -: 8];
    end

    assign bus.out_last  = (state == SEND) && (oidx == 4'd8);
    assign bus.busy      = (state != LOAD);
    assign bus.err       = err_q;
    assign bus.mm_A_flat = a_q;
    assign bus.mm_B_flat = b_q;

endmodule

// File: tb/tb_matmul_stream_host.sv
// Directed bench for matmul_stream_host with a delayed-done multiplier
// model and a queue of expected result elements.
module tb_matmul_stream_host;

    typedef logic [7:0] mat_t [9];

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    matmul_stream_host_if ifc();

    matmul_stream_host #(.DONE_TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] exp_q[$];

    function automatic logic [71:0] pack(mat_t m);
        logic [71:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) r[71-8*k -: 8] = m[k];
        return r;
    endfunction

    function automatic mat_t unpack(logic [71:0] f);
        mat_t m;
        for (int k = 0; k < 9; k++) m[k] = f[71-8*k -: 8];
        return m;
    endfunction

    function automatic mat_t mm_ref(mat_t a, mat_t b);
        mat_t c;
        int s;
        for (int r = 0; r < 3; r++)
            for (int q = 0; q < 3; q++) begin
                s = 0;
                for (int j = 0; j < 3; j++)
                    s += int'(a[3*r+j]) * int'(b[3*j+q]);
                c[3*r+q] = 8'(s);
            end
        return c;
    endfunction

    // Multiplier model: done rises 4 cycles after start, held until next start.
    logic [71:0] mdl_c = '0;
    logic        mdl_done;
    int          mdl_cnt;
    bit          mdl_en = 1'b1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdl_done <= 1'b0;
            mdl_cnt  <= 0;
        end else if (ifc.mm_start) begin
            mdl_done <= 1'b0;
            mdl_cnt  <= 4;
            mdl_c    <= pack(mm_ref(unpack(ifc.mm_A_flat),
                                    unpack(ifc.mm_B_flat)));
        end else if (mdl_cnt > 1) begin
            mdl_cnt <= mdl_cnt - 1;
        end else if (mdl_cnt == 1) begin
            mdl_cnt  <= 0;
            mdl_done <= mdl_en;
        end
    end

    assign ifc.mm_done   = mdl_done;
    assign ifc.mm_C_flat = mdl_c;

    task automatic check(input string tag, input logic [71:0] obs,
                         input logic [71:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push_exp(input mat_t c);
        for (int k = 0; k < 9; k++) exp_q.push_back(c[k]);
    endtask

    // Stream A then B; optional random idle gaps. Ends in START.
    task automatic load_job(input mat_t a, input mat_t b, input bit gaps);
        int k = 0;
        int cyc = 0;
        while (k < 18 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                ifc.in_valid = 1'b0;
                ifc.in_data  = 8'($urandom);
            end else begin
                ifc.in_valid = 1'b1;
                ifc.in_data  = (k < 9) ? a[k] : b[k-9];
            end
            if (ifc.in_valid && ifc.in_ready) k++;
        end
        @(negedge clk);
        ifc.in_valid = 1'b0;
        check("accepted", 72'(k), 72'd18);
        check("start_pulse", 72'(ifc.mm_start), 72'd1);
        check("start_in_ready", 72'(ifc.in_ready), 72'd0);
        check("a_flat", ifc.mm_A_flat, pack(a));
        check("b_flat", ifc.mm_B_flat, pack(b));
    endtask

    // Drain results; stall toggles out_ready; abort_at>=0 resets mid-send.
    task automatic collect(input bit stall, input int abort_at);
        int got = 0;
        int cyc = 0;
        int rdy_seen = 0;
        int start_seen = 0;
        bit stalled = 1'b0;
        logic [7:0] held = '0;
        logic held_last = 1'b0;
        logic [7:0] e;
        logic rdy;
        ifc.out_ready = 1'b0;
        while (got < 9 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (ifc.in_ready) rdy_seen++;
            if (ifc.mm_start) start_seen++;
            if (got == abort_at && ifc.out_valid) begin
                reset = 1'b0;
                ifc.out_ready = 1'b0;
                break;
            end
            if (ifc.out_valid) begin
                if (stalled) begin
                    check("stall_data", 72'(ifc.out_data), 72'(held));
                    check("stall_last", 72'(ifc.out_last), 72'(held_last));
                end
                rdy = stall ? ~ifc.out_ready : 1'b1;
                ifc.out_ready = rdy;
                if (rdy) begin
                    e = exp_q.pop_front();
                    check("out_data", 72'(ifc.out_data), 72'(e));
                    check("out_last", 72'(ifc.out_last), 72'(got == 8));
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held      = ifc.out_data;
                    held_last = ifc.out_last;
                end
            end else begin
                ifc.out_ready = 1'b0;
            end
        end
        check("busy_in_ready", 72'(rdy_seen), 72'd0);
        check("single_start", 72'(start_seen), 72'd0);
        if (abort_at < 0) begin
            check("handshakes", 72'(got), 72'd9);
            @(negedge clk);
            ifc.out_ready = 1'b0;
            check("end_out_valid", 72'(ifc.out_valid), 72'd0);
            check("end_in_ready", 72'(ifc.in_ready), 72'd1);
        end
    endtask

    initial begin
        mat_t a1, b1, idn, twos, c1, twelve;
        int wcyc;
        int ov_seen;
        a1   = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        b1   = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        c1   = '{8'd30, 8'd24, 8'd18, 8'd84, 8'd69, 8'd54,
                 8'd138, 8'd114, 8'd90};
        idn  = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
        twos = '{default: 8'd2};
        twelve = '{default: 8'd12};

        ifc.in_valid  = 1'b0;
        ifc.in_data   = 8'd0;
        ifc.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", 72'(ifc.in_ready), 72'd0);
        check("rst_mm_start", 72'(ifc.mm_start), 72'd0);
        check("rst_out_valid", 72'(ifc.out_valid), 72'd0);
        check("rst_out_last", 72'(ifc.out_last), 72'd0);
        check("rst_busy", 72'(ifc.busy), 72'd0);
        check("rst_err", 72'(ifc.err), 72'd0);
        check("rst_a", ifc.mm_A_flat, 72'd0);
        check("rst_b", ifc.mm_B_flat, 72'd0);
        check("rst_out_data", 72'(ifc.out_data), 72'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_in_ready", 72'(ifc.in_ready), 72'd1);

        // Basic job, continuous valid and ready.
        load_job(a1, b1, 1'b0);
        push_exp(c1);
        collect(1'b0, -1);

        // Same job with out_ready toggling.
        load_job(a1, b1, 1'b0);
        push_exp(c1);
        collect(1'b1, -1);

        // Random input gaps.
        load_job(b1, a1, 1'b1);
        push_exp(mm_ref(b1, a1));
        collect(1'b0, -1);

        // Back-to-back: identity B, then all twos.
        load_job(a1, idn, 1'b0);
        push_exp(a1);
        collect(1'b0, -1);
        check("err_job1", 72'(ifc.err), 72'd0);
        load_job(twos, twos, 1'b0);
        push_exp(twelve);
        collect(1'b0, -1);
        check("err_job2", 72'(ifc.err), 72'd0);

        // Timeout: multiplier never answers.
        mdl_en = 1'b0;
        load_job(a1, b1, 1'b0);
        wcyc = 0;
        ov_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ifc.out_valid) ov_seen++;
            if (ifc.in_ready) break;
            if (ifc.busy) wcyc++;
        end
        check("to_wait_cycles", 72'(wcyc), 72'd16);
        check("to_err", 72'(ifc.err), 72'd1);
        check("to_in_ready", 72'(ifc.in_ready), 72'd1);
        check("to_no_output", 72'(ov_seen), 72'd0);
        mdl_en = 1'b1;

        // Job after timeout still works with err held.
        load_job(a1, idn, 1'b0);
        push_exp(a1);
        collect(1'b0, -1);
        check("err_sticky", 72'(ifc.err), 72'd1);

        // Reset during SEND at oidx 4.
        load_job(a1, b1, 1'b0);
        push_exp(c1);
        collect(1'b0, 4);
        #1;
        check("ab_out_valid", 72'(ifc.out_valid), 72'd0);
        check("ab_in_ready", 72'(ifc.in_ready), 72'd0);
        check("ab_busy", 72'(ifc.busy), 72'd0);
        check("ab_err", 72'(ifc.err), 72'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("ab_rel_in_ready", 72'(ifc.in_ready), 72'd1);
        check("ab_rel_out_valid", 72'(ifc.out_valid), 72'd0);
        load_job(a1, b1, 1'b0);
        push_exp(c1);
        collect(1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
